// File: rtl/fpmac_pkg.sv
// Shared definitions for the floating-point MAC datapath: precision codes,
// hidden-one positions, exponent limits and the normalized bundle layout.
package fpmac_pkg;

  localparam logic OP_HALF   = 1'b0;
  localparam logic OP_SINGLE = 1'b1;

  localparam int H_HALF      = 20;
  localparam int H_SINGLE    = 46;

  localparam int EMAX_HALF   = 31;
  localparam int EMAX_SINGLE = 255;

  localparam int MW          = 50;

  // Normalized bundle handed to the rounding stage
  typedef struct packed {
    logic          op;
    logic          s;
    logic [7:0]    e;
    logic [MW-1:0] m;
  } nor_bundle_t;

endpackage

// File: rtl/normalize_lead_one_det.sv
// Combinational leading-one detector: index of the most significant set bit
// of m, plus a flag for an all-zero input (p is 0 in that case).
module lead_one_det #(
  parameter int W = 50
) (
  input  logic [W-1:0] m,
  output logic [5:0]   p,
  output logic         zero
);

  // Scan upward so the highest set bit is the last one recorded
  always_comb begin
    p    = '0;
    zero = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (m[i]) begin
        p    = 6'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/normalize.sv
// Two-stage normalizer: stage 1 captures the accumulator sum and finds its
// leading one; stage 2 aligns it to the hidden-one position, folds shifted-out
// bits into a sticky bit and classifies zero / infinity / flush / normal.
module normalize #(
  parameter int MW = 50,
  parameter int EW = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 add_valid,
  output logic                 add_ready,
  input  logic                 add_op,
  input  logic                 add_s,
  input  logic signed [EW-1:0] add_e,
  input  logic [MW-1:0]        add_m,
  output logic                 nor_valid,
  input  logic                 nor_ready,
  output logic                 nor_op,
  output logic                 nor_s,
  output logic [7:0]           nor_e,
  output logic [MW-1:0]        nor_m
);

  import fpmac_pkg::*;

  // Align, collect sticky and classify one bundle
  function automatic nor_bundle_t norm_fn(
    input logic                 op,
    input logic                 s,
    input logic signed [EW-1:0] e,
    input logic [MW-1:0]        m,
    input logic [5:0]           p,
    input logic                 zero
  );
    nor_bundle_t         r;
    int                  h;
    int                  d;
    logic signed [EW:0]  ex;
    logic signed [EW:0]  emax;
    logic [MW-1:0]       sh;
    logic [MW-1:0]       mask;
    h    = (op == OP_SINGLE) ? H_SINGLE : H_HALF;
    emax = (op == OP_SINGLE) ? (EW+1)'(EMAX_SINGLE) : (EW+1)'(EMAX_HALF);
    d    = int'(p) - h;
    mask = '0;
    if (d > 0) begin
      mask  = {MW{1'b1}} >> (MW - d);
      sh    = m >> d;
      sh[0] = sh[0] | (|(m & mask));
    end else begin
      sh = m << (-d);
    end
    // One extra bit of headroom keeps add_e + d from wrapping
    ex   = {e[EW-1], e} + (EW+1)'(d);
    r.op = op;
    r.s  = s;
    r.e  = '0;
    r.m  = '0;
    if (zero) begin
      r.e = '0;
    end else if (ex >= emax) begin
      r.e = emax[7:0];
    end else if (!ex[EW] && (ex != '0)) begin
      r.e = ex[7:0];
      r.m = sh;
    end
    return r;
  endfunction

  logic                 adv1;
  logic                 adv2;

  logic                 vld_p1;
  logic                 op_p1;
  logic                 s_p1;
  logic signed [EW-1:0] e_p1;
  logic [MW-1:0]        m_p1;
  logic [5:0]           p_p1;
  logic                 zero_p1;

  logic [5:0]           p_in;
  logic                 zero_in;

  logic                 vld_p2;
  nor_bundle_t          res_d;
  nor_bundle_t          res_p2;

  assign adv2      = !vld_p2 || nor_ready;
  assign adv1      = !vld_p1 || adv2;
  assign add_ready = adv1;

  lead_one_det #(.W(MW)) u_lod (
    .m    (add_m),
    .p    (p_in),
    .zero (zero_in)
  );

  // ---- stage 1: capture and leading-one detect ----

  // Stage 1 occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (adv1) begin
      vld_p1 <= add_valid;
    end
  end

  // Stage 1 payload, loaded only on an input transfer
  always_ff @(posedge clk) begin
    if (adv1 && add_valid) begin
      op_p1   <= add_op;
      s_p1    <= add_s;
      e_p1    <= add_e;
      m_p1    <= add_m;
      p_p1    <= p_in;
      zero_p1 <= zero_in;
    end
  end

  // ---- stage 2: shift, sticky and classification ----

  // Compute the normalized bundle from the stage 1 registers
  always_comb begin
    res_d = norm_fn(op_p1, s_p1, e_p1, m_p1, p_p1, zero_p1);
  end

  // Stage 2 occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
    end
  end

  // Stage 2 payload, loaded when stage 1 hands over a bundle
  always_ff @(posedge clk) begin
    if (adv2 && vld_p1) begin
      res_p2 <= res_d;
    end
  end

  // Outputs read as zero whenever no bundle is presented
  assign nor_valid = vld_p2;
  assign nor_op    = vld_p2 & res_p2.op;
  assign nor_s     = vld_p2 & res_p2.s;
  assign nor_e     = vld_p2 ? res_p2.e : 8'd0;
  assign nor_m     = vld_p2 ? res_p2.m : '0;

endmodule
